frame_stream_arbiter: RTL and testbench

- Shares one downstream video_out stage between two upstream pixel streams (e.g. camera path and test-pattern path).
- Uses the valid/ready/sop/eop streaming handshake.
- Arbitrates at frame granularity: a granted source owns the output from its sop beat through its eop beat.
- Round-robin between sources; drops orphan (non-sop) beats while idle so the downstream never sees a partial frame.

---
 rtl/video_pkg.sv | 11 +
 rtl/rr_arb2.sv | 21 ++
 rtl/frame_stream_arbiter.sv | 156 +++++++++++++++
 tb/tb_frame_stream_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared encodings for the frame-level stream arbiter: FSM states and one-hot grant values.
package video_pkg;

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_PASS  = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin priority: a lone request wins outright, a tie goes to the
// source that did not own the previous frame.
module rr_arb2
    import video_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_S0;
            2'b10:   gnt = GNT_S1;
            2'b11:   gnt = last_grant ? GNT_S0 : GNT_S1;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Shares one video output between two pixel streams, switching owners only on frame
// boundaries and discarding orphan beats that arrive while no frame is in flight.
module frame_stream_arbiter
    import video_pkg::*;
#(
    parameter int BITWDITH  = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BITWDITH-1:0]  sink0_data,
    input  logic                 sink0_valid,
    input  logic                 sink0_sop,
    input  logic                 sink0_eop,
    output logic                 sink0_ready,
    input  logic [BITWDITH-1:0]  sink1_data,
    input  logic                 sink1_valid,
    input  logic                 sink1_sop,
    input  logic                 sink1_eop,
    output logic                 sink1_ready,
    output logic [BITWDITH-1:0]  source_data,
    output logic                 source_valid,
    output logic                 source_sop,
    output logic                 source_eop,
    input  logic                 source_ready,
    input  logic [1:0]           enable,
    output logic [1:0]           grant,
    output logic [CNT_WIDTH-1:0] frame_cnt0,
    output logic [CNT_WIDTH-1:0] frame_cnt1,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    logic                 state_reg, state_next;
    logic [1:0]           grant_reg, grant_next;
    logic                 last_grant_reg, last_grant_next;
    logic [CNT_WIDTH-1:0] frame_cnt0_reg, frame_cnt0_next;
    logic [CNT_WIDTH-1:0] frame_cnt1_reg, frame_cnt1_next;
    logic [CNT_WIDTH-1:0] drop_cnt_reg, drop_cnt_next;

    logic [1:0] sink_valid;
    logic [1:0] sink_sop;
    logic [1:0] req;
    logic [1:0] orphan;
    logic [1:0] arb_gnt;
    logic [1:0] drop_inc;
    logic       pass_xfer;

    assign sink_valid = {sink1_valid, sink1_valid & 1'b1} & {1'b1, 1'b0} | {1'b0, sink0_valid};
    assign sink_sop   = {sink1_sop, sink0_sop};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sink
            assign req[gi]    = enable[gi] & sink_valid[gi] & sink_sop[gi];
            assign orphan[gi] = enable[gi] & sink_valid[gi] & ~sink_sop[gi];
        end
    endgenerate

    assign drop_inc = {1'b0, orphan[0]} + {1'b0, orphan[1]};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_reg),
        .gnt        (arb_gnt)
    );

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= GNT_NONE;
            last_grant_reg <= 1'b1;
            frame_cnt0_reg <= '0;
            frame_cnt1_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            frame_cnt0_reg <= frame_cnt0_next;
            frame_cnt1_reg <= frame_cnt1_next;
            drop_cnt_reg   <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        frame_cnt0_next = frame_cnt0_reg;
        frame_cnt1_next = frame_cnt1_reg;
        drop_cnt_next   = drop_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                drop_cnt_next = sat_add(drop_cnt_reg, drop_inc);
                if (arb_gnt != GNT_NONE) begin
                    state_next = ST_PASS;
                    grant_next = arb_gnt;
                end
            end
            default: begin
                // Only the eop transfer releases ownership; mid-frame sop is just data.
                if (pass_xfer && source_eop) begin
                    state_next      = ST_IDLE;
                    grant_next      = GNT_NONE;
                    last_grant_next = grant_reg[1];
                    if (grant_reg[1])
                        frame_cnt1_next = frame_cnt1_reg + 1'b1;
                    else
                        frame_cnt0_next = frame_cnt0_reg + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        source_data  = '0;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        sink0_ready  = 1'b0;
        sink1_ready  = 1'b0;
        if (!rst) begin
            if (state_reg == ST_PASS) begin
                if (grant_reg[1]) begin
                    source_data  = sink1_data;
                    source_valid = sink1_valid;
                    source_sop   = sink1_sop;
                    source_eop   = sink1_eop;
                    sink1_ready  = source_ready;
                end else begin
                    source_data  = sink0_data;
                    source_valid = sink0_valid;
                    source_sop   = sink0_sop;
                    source_eop   = sink0_eop;
                    sink0_ready  = source_ready;
                end
            end else begin
                sink0_ready = orphan[0];
                sink1_ready = orphan[1];
            end
        end
    end

    assign pass_xfer  = source_valid & source_ready;
    assign grant      = grant_reg;
    assign frame_cnt0 = frame_cnt0_reg;
    assign frame_cnt1 = frame_cnt1_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Scoreboard bench: each driven beat is queued per source and popped when it appears downstream.
module tb_frame_stream_arbiter;

    localparam int W  = 24;
    localparam int CW = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_data0, s_data1;
    logic [1:0]    s_valid, s_sop, s_eop;
    logic          sink0_ready, sink1_ready;
    logic [W-1:0]  source_data;
    logic          source_valid, source_sop, source_eop;
    logic          source_ready;
    logic [1:0]    enable;
    logic [1:0]    grant;
    logic [CW-1:0] frame_cnt0, frame_cnt1, drop_cnt;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    order_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    last_eop_cyc = -1;
    bit    chk_order   = 1'b0;
    logic [0:3] bp_pat = 4'b1001;

    always #5 clk = ~clk;

    frame_stream_arbiter #(.BITWDITH(W), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sink0_data   (s_data0),
        .sink0_valid  (s_valid[0]),
        .sink0_sop    (s_sop[0]),
        .sink0_eop    (s_eop[0]),
        .sink0_ready  (sink0_ready),
        .sink1_data   (s_data1),
        .sink1_valid  (s_valid[1]),
        .sink1_sop    (s_sop[1]),
        .sink1_eop    (s_eop[1]),
        .sink1_ready  (sink1_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_ready (source_ready),
        .enable       (enable),
        .grant        (grant),
        .frame_cnt0   (frame_cnt0),
        .frame_cnt1   (frame_cnt1),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the owner's queue on every downstream transfer.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        if (!chk_order) last_eop_cyc = -1;
        if (!rst && source_valid && source_ready) begin
            got = '{data: source_data, sop: source_sop, eop: source_eop};
            if (grant == 2'b01) begin
                if (exp_q0.size() == 0) check("sb0_depth", exp_q0.size(), 1);
                else begin
                    exp = exp_q0.pop_front();
                    check("beat_s0", 32'(got), 32'(exp));
                end
            end else if (grant == 2'b10) begin
                if (exp_q1.size() == 0) check("sb1_depth", exp_q1.size(), 1);
                else begin
                    exp = exp_q1.pop_front();
                    check("beat_s1", 32'(got), 32'(exp));
                end
            end else begin
                check("valid_grant", 32'(grant), 32'h1);
            end
            if (chk_order && source_sop) begin
                order_q.push_back(grant == 2'b10 ? 1 : 0);
                if (last_eop_cyc >= 0) check("idle_gap", cyc - last_eop_cyc, 2);
            end
            if (chk_order && source_eop) last_eop_cyc = cyc;
        end
    end

    task automatic wait_xfer(input int src);
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = (src == 0) ? sink0_ready : sink1_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) check("xfer_timeout", 0, 1);
    endtask

    // Drives an n-beat frame; stops with beat stop_at presented (not queued) when stop_at < n.
    task automatic send_frame(input int src, input int n, input int tag, input int stop_at);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.data = {8'(src), 8'(tag), 8'(b)};
            bt.sop  = (b == 0);
            bt.eop  = (b == n - 1);
            if (src == 0) s_data0 = bt.data;
            else          s_data1 = bt.data;
            s_valid[src] = 1'b1;
            s_sop[src]   = bt.sop;
            s_eop[src]   = bt.eop;
            if (b == stop_at) return;
            if (src == 0) exp_q0.push_back(bt);
            else          exp_q1.push_back(bt);
            wait_xfer(src);
            #1;
        end
        s_valid[src] = 1'b0;
        s_sop[src]   = 1'b0;
        s_eop[src]   = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        enable = 2'b11;
        s_data0 = '0;
        s_data1 = '0;
        s_valid = 2'b10;
        s_sop = 2'b00;
        s_eop = 2'b00;
        source_ready = 1'b1;

        // Reset: an orphan is presented but nothing may be accepted.
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_valid", 32'(source_valid), 0);
        check("rst_ready", 32'({sink1_ready, sink0_ready}), 0);
        check("rst_cnt", 32'({frame_cnt0, frame_cnt1}), 0);
        s_valid = 2'b00;
        rst = 1'b0;

        // Single source, 8-beat frame.
        enable = 2'b01;
        @(posedge clk); #1;
        fork
            send_frame(0, 8, 1, 8);
            begin
                @(negedge clk);
                check("gnt_wait", 32'(grant), 0);
                check("gnt_wait_ready", 32'(sink0_ready), 0);
                @(negedge clk);
                check("gnt_s0", 32'(grant), 1);
            end
        join
        @(negedge clk);
        check("gnt_after_eop", 32'(grant), 0);
        check("frame_cnt0_single", 32'(frame_cnt0), 1);
        check("sb0_drained", exp_q0.size(), 0);

        // Contention from reset: expect 0,1,0,1 with one idle cycle per switch.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 2'b11;
        chk_order = 1'b1;
        @(posedge clk); #1;
        fork
            begin send_frame(0, 3, 2, 3); send_frame(0, 3, 4, 3); end
            begin send_frame(1, 3, 3, 3); send_frame(1, 3, 5, 3); end
        join
        @(negedge clk);
        chk_order = 1'b0;
        check("order_len", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check("order", order_q[i], i % 2);
        check("frame_cnt0_rr", 32'(frame_cnt0), 2);
        check("frame_cnt1_rr", 32'(frame_cnt1), 2);

        // Orphans: three from source 1, then one from each source together.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            s_valid[1] = 1'b1;
            s_sop[1]   = 1'b0;
            s_data1    = 24'(i + 16'h0A00);
            @(negedge clk);
            check("orphan_ready1", 32'(sink1_ready), 1);
            check("orphan_nvalid", 32'(source_valid), 0);
            @(posedge clk); #1;
        end
        s_valid = 2'b00;
        @(negedge clk);
        check("drop_cnt3", 32'(drop_cnt), 3);
        @(posedge clk); #1;
        s_valid = 2'b11;
        @(negedge clk);
        check("orphan_ready_both", 32'({sink1_ready, sink0_ready}), 32'h3);
        @(posedge clk); #1;
        s_valid = 2'b00;
        @(negedge clk);
        check("drop_cnt5", 32'(drop_cnt), 5);

        // Backpressure during PASS.
        enable = 2'b01;
        @(posedge clk); #1;
        fork
            send_frame(0, 4, 6, 4);
            begin
                logic [W-1:0] held;
                held = '0;
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    source_ready = bp_pat[i];
                    @(negedge clk);
                    check("bp_ready", 32'(sink0_ready), 32'(bp_pat[i]));
                    if (i == 1) held = source_data;
                    if (i == 2) check("bp_hold", 32'(source_data), 32'(held));
                    @(posedge clk); #1;
                end
                source_ready = 1'b1;
            end
        join
        @(negedge clk);
        check("frame_cnt0_bp", 32'(frame_cnt0), 3);

        // Enable masking: disabled source 0 holds sop; enable[1] drops mid-frame.
        enable = 2'b10;
        @(posedge clk); #1;
        s_data0 = 24'h00BEEF;
        s_valid[0] = 1'b1;
        s_sop[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mask_idle_gnt", 32'(grant), 0);
            check("mask_idle_ready0", 32'(sink0_ready), 0);
        end
        @(posedge clk); #1;
        fork
            send_frame(1, 4, 7, 4);
            begin
                @(posedge clk); #1;
                enable = 2'b00;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("mask_gnt", 32'(grant), 2);
                    check("mask_ready0", 32'(sink0_ready), 0);
                end
            end
        join
        @(negedge clk);
        check("frame_cnt1_mask", 32'(frame_cnt1), 3);
        check("mask_after_gnt", 32'(grant), 0);
        s_valid = 2'b00;
        s_sop = 2'b00;

        // Reset mid-frame at beat 3 of 8.
        enable = 2'b01;
        @(posedge clk); #1;
        send_frame(0, 8, 8, 2);
        #1 rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(source_valid), 0);
        check("rstmid_grant", 32'(grant), 0);
        check("rstmid_ready", 32'(sink0_ready), 0);
        check("rstmid_cnt", 32'({frame_cnt0, frame_cnt1}), 0);
        check("rstmid_drop", 32'(drop_cnt), 0);
        s_valid = 2'b00;
        s_sop = 2'b00;
        s_eop = 2'b00;
        exp_q0.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(0, 2, 9, 2);
        @(negedge clk);
        check("rstmid_after_cnt", 32'(frame_cnt0), 1);
        check("rstmid_after_gnt", 32'(grant), 0);
        check("sb_final", exp_q0.size() + exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
